// File: rtl/crossbar_master_port_if.sv
// Stream bundle between one crossbar master port stage and its surroundings:
// slave streams in, arbiter request/grant, and the registered master stream out.
interface crossbar_master_port_if #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
);
  logic [S_DATA_COUNT*T_DATA_WIDTH-1:0] s_data_i;
  logic [S_DATA_COUNT-1:0]              s_valid_i;
  logic [S_DATA_COUNT-1:0]              s_last_i;
  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i;
  logic [S_DATA_COUNT-1:0]              s_ready_o;
  logic [S_DATA_COUNT-1:0]              request_mask_o;
  logic [S_DATA_COUNT-1:0]              grant_i;
  logic [T_DATA_WIDTH-1:0]              m_data_o;
  logic                                 m_valid_o;
  logic                                 m_last_o;
  logic [T_ID___WIDTH-1:0]              m_id_o;
  logic                                 m_ready_i;

  // master: the port stage itself; slave: the slave streams, arbiter and sink
  modport master (
    input  s_data_i, s_valid_i, s_last_i, s_dest_i, grant_i, m_ready_i,
    output s_ready_o, request_mask_o, m_data_o, m_valid_o, m_last_o, m_id_o
  );
  modport slave (
    output s_data_i, s_valid_i, s_last_i, s_dest_i, grant_i, m_ready_i,
    input  s_ready_o, request_mask_o, m_data_o, m_valid_o, m_last_o, m_id_o
  );
endinterface

// File: rtl/crossbar_master_port.sv
// Per-master-port packet stage: dest decode, arbiter request mask, packet lock
// on the granted source, and a 2-entry FIFO feeding the registered master stream.
module crossbar_master_port #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int PORT_INDEX   = 0,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input logic                   clk,
  input logic                   rst,
  crossbar_master_port_if.master bus
);
  localparam logic [T_DEST_WIDTH-1:0] PORT_DEST = T_DEST_WIDTH'(PORT_INDEX % M_DATA_COUNT);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic                    last;
    logic [T_ID___WIDTH-1:0] id;
  } beat_t;

  logic [0:0]              state_q, state_d;
  logic [T_ID___WIDTH-1:0] lock_id_q, lock_id_d;
  logic [1:0]              count_q, count_d;
  beat_t                   head_q, head_d, tail_q, tail_d;

  logic [S_DATA_COUNT-1:0] hit, lock_oh, sel_oh;
  logic                    busy, sel_ok, in_rdy, push, pop;
  beat_t                   in_beat;

  assign busy = (state_q == BUSY);

  always_comb begin
    hit     = '0;
    lock_oh = '0;
    for (int k = 0; k < S_DATA_COUNT; k++) begin
      hit[k]     = bus.s_valid_i[k] & (bus.s_dest_i[k*T_DEST_WIDTH +: T_DEST_WIDTH] == PORT_DEST);
      lock_oh[k] = (lock_id_q == T_ID___WIDTH'(k));
    end
  end

  // Once locked the grant is ignored; the locked source alone may move beats.
  assign sel_oh = busy ? lock_oh : bus.grant_i;
  assign sel_ok = busy ? |(hit & lock_oh) : ($onehot(bus.grant_i) & |(hit & bus.grant_i));
  assign in_rdy = sel_ok & (count_q != 2'd2) & ~rst;

  assign bus.s_ready_o      = in_rdy ? sel_oh : '0;
  assign bus.request_mask_o = rst ? '0 : (busy ? (hit & lock_oh) : hit);

  always_comb begin
    in_beat = '0;
    for (int k = 0; k < S_DATA_COUNT; k++) begin
      if (sel_oh[k]) begin
        in_beat.data = bus.s_data_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
        in_beat.last = bus.s_last_i[k];
        in_beat.id   = T_ID___WIDTH'(k);
      end
    end
  end

  assign push = |(bus.s_valid_i & bus.s_ready_o);
  assign pop  = (count_q != 2'd0) & bus.m_ready_i;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    if (push) begin
      if (in_beat.last) begin
        state_d = IDLE;
      end else begin
        state_d   = BUSY;
        lock_id_d = in_beat.id;
      end
    end
  end

  // Head is always the oldest beat; push never happens while full.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_beat;
        else                 tail_d = in_beat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_beat;
        end else begin
          head_d = tail_q;
          tail_d = in_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  assign bus.m_data_o  = head_q.data;
  assign bus.m_last_o  = head_q.last;
  assign bus.m_id_o    = head_q.id;
  assign bus.m_valid_o = (count_q != 2'd0);
endmodule

// File: tb/tb_crossbar_master_port.sv
// Randomized and directed checks of crossbar_master_port against a packet-level
// model; accepted beats go to a scoreboard queue drained by an output monitor.
module tb_crossbar_master_port;
  localparam int DW = 8;
  localparam int S  = 5;
  localparam int M  = 3;
  localparam int P  = 0;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crossbar_master_port_if #(.T_DATA_WIDTH(DW), .S_DATA_COUNT(S), .M_DATA_COUNT(M)) bus ();

  crossbar_master_port #(
    .T_DATA_WIDTH(DW), .S_DATA_COUNT(S), .M_DATA_COUNT(M), .PORT_INDEX(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            id;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    passes = 0;
  int    lock_src = -1;  // -1: no packet in progress
  int    occ = 0;        // beats accepted and not yet taken by the sink
  bit    acc;

  logic [DW-1:0] dat [S];
  logic [TW-1:0] dst [S];
  logic [S-1:0]  vld, lst, gnt;
  logic          mrdy;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_in();
    vld = '0; lst = '0; gnt = '0; mrdy = 1'b1;
    for (int k = 0; k < S; k++) begin dat[k] = '0; dst[k] = TW'(P); end
  endtask

  // Drive the current stimulus for one cycle, check against the model, advance it.
  task automatic tick();
    logic [S-1:0] hit, er, em;
    int  sel;
    bit  ok, pop;
    for (int k = 0; k < S; k++) begin
      bus.s_data_i[k*DW +: DW] = dat[k];
      bus.s_dest_i[k*TW +: TW] = dst[k];
    end
    bus.s_valid_i = vld;
    bus.s_last_i  = lst;
    bus.grant_i   = gnt;
    bus.m_ready_i = mrdy;
    @(negedge clk);
    for (int k = 0; k < S; k++) hit[k] = vld[k] && (int'(dst[k]) == P);
    sel = -1;
    if (lock_src < 0) begin
      em = hit;
      if ($countones(gnt) == 1)
        for (int k = 0; k < S; k++) if (gnt[k]) sel = k;
      ok = (sel >= 0) && hit[sel];
    end else begin
      em  = hit & (S'(1) << lock_src);
      sel = lock_src;
      ok  = hit[sel];
    end
    er = (ok && occ < 2) ? (S'(1) << sel) : '0;
    if (rst) begin er = '0; em = '0; end
    chk("s_ready", int'(bus.s_ready_o), int'(er));
    chk("req_mask", int'(bus.request_mask_o), int'(em));
    chk("m_valid", int'(bus.m_valid_o), int'(occ != 0));
    acc = 1'b0;
    if (rst) begin
      lock_src = -1;
      occ = 0;
      exp_q.delete();
    end else begin
      pop = (occ != 0) && mrdy;
      if (er != '0) begin
        beat_t b;
        acc = 1'b1;
        b.data = dat[sel]; b.last = lst[sel]; b.id = sel;
        exp_q.push_back(b);
        lock_src = lst[sel] ? -1 : sel;
      end
      occ = occ + int'(acc) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in(bit slow_sink);
    int hits[$];
    for (int k = 0; k < S; k++) begin
      vld[k] = ($urandom_range(0, 3) != 0);
      dst[k] = $urandom_range(0, 1) ? TW'(P) : TW'($urandom_range(0, 3));
      lst[k] = ($urandom_range(0, 3) == 0);
      dat[k] = DW'($urandom);
      if (vld[k] && int'(dst[k]) == P) hits.push_back(k);
    end
    if (hits.size() != 0 && $urandom_range(0, 4) != 0)
      gnt = S'(1) << hits[$urandom_range(0, hits.size() - 1)];
    else
      gnt = S'($urandom);
    mrdy = slow_sink ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.m_valid_o && bus.m_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL m_beat: got data %0h id %0d, expected no beat", bus.m_data_o, bus.m_id_o);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("m_beat", int'({bus.m_data_o, bus.m_last_o, bus.m_id_o}),
            int'({b.data, b.last, 3'(b.id)}));
      end
    end
  end

  initial begin
    int i;
    logic [DW-1:0] bp [4];
    idle_in();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_m_data", int'(bus.m_data_o), 0);
    chk("rst_m_last", int'(bus.m_last_o), 0);
    chk("rst_m_id", int'(bus.m_id_o), 0);
    chk("rst_m_valid", int'(bus.m_valid_o), 0);
    rst = 1'b0;
    tick();

    // single 3-beat packet from slave 2
    vld = 5'b00100; gnt = 5'b00100;
    dat[2] = 8'hA1; tick();
    dat[2] = 8'hA2; tick();
    dat[2] = 8'hA3; lst[2] = 1'b1; tick();
    idle_in(); repeat (3) tick();

    // lock on slave 0 while the arbiter moves to slave 3
    vld = 5'b01001; gnt = 5'b00001; lst[3] = 1'b1;
    dat[0] = 8'hB1; dat[3] = 8'hC1; tick();
    gnt = 5'b01000;
    dat[0] = 8'hB2; tick();
    dat[0] = 8'hB3; lst[0] = 1'b1; tick();
    vld = 5'b01000; tick();
    idle_in(); repeat (3) tick();

    // back-pressure on a 4-beat packet from slave 1
    bp = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    vld = 5'b00010; gnt = 5'b00010; mrdy = 1'b0; i = 0;
    repeat (5) begin
      dat[1] = bp[i]; lst[1] = (i == 3); tick();
      if (acc) i++;
    end
    mrdy = 1'b1;
    for (int n = 0; n < 20 && i < 4; n++) begin
      dat[1] = bp[i]; lst[1] = (i == 3); tick();
      if (acc) i++;
    end
    chk("bp_all_accepted", i, 4);
    idle_in(); repeat (3) tick();

    // dest filter and bad grants
    vld = 5'b00110; dst[1] = 2'd1; dat[1] = 8'h55; dat[2] = 8'h66; lst = 5'b00110;
    gnt = 5'b00110; tick();
    gnt = 5'b00010; tick();
    gnt = 5'b00000; tick();
    gnt = 5'b00100; tick();
    idle_in(); repeat (2) tick();

    // back-to-back single-beat packets
    vld = 5'b10000; lst = 5'b10000; gnt = 5'b10000; dat[4] = 8'h10; tick();
    vld = 5'b00001; lst = 5'b00001; gnt = 5'b00001; dat[0] = 8'h20; tick();
    idle_in(); repeat (3) tick();

    // reset in the middle of a stalled packet, then a fresh packet
    vld = 5'b00100; gnt = 5'b00100; mrdy = 1'b0;
    dat[2] = 8'hE1; tick();
    dat[2] = 8'hE2; tick();
    rst = 1'b1; dat[2] = 8'hE3; tick();
    rst = 1'b0; idle_in(); tick();
    vld = 5'b01000; lst = 5'b01000; gnt = 5'b01000; dat[3] = 8'hF1; tick();
    idle_in(); repeat (3) tick();

    // random traffic with alternating sink speed
    for (int n = 0; n < 2000; n++) begin
      rand_in((n / 100) % 3 == 1);
      tick();
    end

    idle_in();
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/crossbar_master_port.md
# crossbar_master_port

Per-master-port packet stage of the streaming crossbar, one instance per master output. It decodes which slave streams target this port and drives the round-robin arbiter's request mask. It consumes the arbiter's one-hot grant and locks that source for a whole packet. It muxes the locked source's beats into a 2-entry output FIFO that drives the registered master stream.

## Interface
Parameters:
- T_DATA_WIDTH, 8, beat data width
- S_DATA_COUNT, 5, number of slave streams
- M_DATA_COUNT, 3, number of master ports
- PORT_INDEX, 0, destination value served by this instance (0..M_DATA_COUNT-1)
- T_ID___WIDTH, $clog2(S_DATA_COUNT), source id width
- T_DEST_WIDTH, $clog2(M_DATA_COUNT), destination width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- s_data_i  in  S_DATA_COUNT*T_DATA_WIDTH  slave data, slave k at bits [k*T_DATA_WIDTH +: T_DATA_WIDTH]
- s_valid_i  in  S_DATA_COUNT  slave valid
- s_last_i  in  S_DATA_COUNT  slave end-of-packet
- s_dest_i  in  S_DATA_COUNT*T_DEST_WIDTH  slave destination, packed like s_data_i
- s_ready_o  out  S_DATA_COUNT  slave ready, combinational
- request_mask_o  out  S_DATA_COUNT  requests to arbiter, combinational
- grant_i  in  S_DATA_COUNT  one-hot grant from arbiter
- m_data_o  out  T_DATA_WIDTH  master data, registered
- m_valid_o  out  1  master valid, registered
- m_last_o  out  1  master end-of-packet, registered
- m_id_o  out  T_ID___WIDTH  source index of the current beat, registered
- m_ready_i  in  1  master ready

## Operation
- Hit decode: hit[k] = s_valid_i[k] & (s_dest_i[k] == PORT_INDEX).
- States: IDLE and BUSY. Registers: lock_id (T_ID___WIDTH), FIFO count (0..2).
- request_mask_o:
  - IDLE: equals hit.
  - BUSY: equals hit masked to bit lock_id, so the arbiter keeps granting the locked source.
- Selection valid (sel_ok):
  - IDLE: grant_i is exactly one-hot and hit[granted] = 1. sel = index of the granted bit.
  - BUSY: sel = lock_id. sel_ok = hit[lock_id]. grant_i is ignored.
  - A zero or multi-hot grant in IDLE means no selection. No beat is accepted.
- s_ready_o[k] = (k == sel) & sel_ok & (count < 2). All other bits are 0.
- Accept: s_valid_i[sel] & s_ready_o[sel]. Pushes {data, last, sel} into the FIFO.
- Transitions:
  - IDLE→BUSY: on an accepted beat with last = 0. lock_id ← sel.
  - BUSY→IDLE: on an accepted beat with last = 1.
  - A single-beat packet (last = 1 while IDLE) stays in IDLE.
- FIFO: 2 entries. The head drives m_data_o, m_last_o, m_id_o. m_valid_o = (count != 0).
  - Pop on m_valid_o & m_ready_i.
  - Push and pop in the same cycle leave count unchanged and preserve order.
- Output payload holds stable while m_valid_o = 1 and m_ready_i = 0.
- Beats from different sources never interleave within a packet at the master output.

## Timing
- Reset values: state IDLE, count 0, lock_id 0, m_valid_o 0, m_data_o 0, m_last_o 0, m_id_o 0.
- While rst = 1, s_ready_o and request_mask_o are forced to 0.
- Reset mid-packet: FIFO contents are discarded, the lock is released, and the first post-reset beat is arbitrated afresh.
- Latency: a beat accepted in cycle N appears on m_valid_o in cycle N+1 when the FIFO was empty.
- Throughput: 1 beat per cycle sustained while m_ready_i = 1.
- Full: count = 2 drives s_ready_o to all zeros.
- Back-pressure: with m_ready_i low, at most 2 beats are accepted before the input stalls.
- Release: on the cycle after the last beat is accepted, the state is IDLE and request_mask_o reflects all current hits.
- Idle gaps: if s_valid_i[lock_id] drops mid-packet, the lock holds indefinitely and other sources receive no grant.

## Test plan
- Single packet: slave 2 sends dest = PORT_INDEX, 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3), grant_i = 5'b00100, m_ready_i = 1 → m_data_o shows A1, A2, A3 in consecutive cycles starting 1 cycle after the first accept; m_id_o = 2; m_last_o = 1 only with 0xA3.
- Lock: slaves 0 and 3 both request; grant 5'b00001 on the first beat; the arbiter then switches grant_i to 5'b01000 mid-packet → only slave 0 beats are accepted until its last; request_mask_o = 5'b00001 during BUSY.
- Back-pressure: m_ready_i = 0 during a 4-beat packet → exactly 2 beats accepted, s_ready_o = 0 afterwards; raising m_ready_i drains the beats in order with no loss or duplication.
- Dest filter and bad grant: slave 1 has dest ≠ PORT_INDEX → request_mask_o[1] = 0 and s_ready_o[1] = 0. grant_i = 5'b00110 in IDLE → no accept.
- Single-beat packets back-to-back: slave 4 sends last = 1 beats 0x10 then slave 0 sends 0x20 → state never leaves IDLE; output is 0x10 (id 4) then 0x20 (id 0).
- Reset mid-packet: assert rst after 2 of 4 beats → the next cycle shows m_valid_o = 0, count = 0, state IDLE; a new packet passes normally.
